// File: rtl/flit_vc_buffer.sv
// Multi-virtual-channel flit FIFO: NUM_VC independent ring buffers with per-VC state reporting.
// Optional: define FLIT_BUF_DROP_NOPE_EN to silently consume NOPE-type flits on push.
module flit_vc_buffer #(
  parameter int unsigned FLIT_WIDTH = 128,
  parameter int unsigned NUM_VC     = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_TH      = 1,
  localparam int unsigned VCW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int unsigned PW        = $clog2(DEPTH),
  localparam int unsigned CW        = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [VCW-1:0]         in_vc,
  input  logic [FLIT_WIDTH-1:0]  in_flit,
  output logic                   in_ready,
  input  logic [VCW-1:0]         out_vc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  output logic [2*NUM_VC-1:0]    vc_state,
  output logic [NUM_VC*CW-1:0]   vc_count,
  output logic                   err_overflow,
  input  logic                   err_clear
);

  typedef enum logic [1:0] {
    StEmpty      = 2'd0,
    StVacant     = 2'd1,
    StAlmostFull = 2'd2,
    StFull       = 2'd3
  } vc_state_e;

  logic [FLIT_WIDTH-1:0] mem_q [NUM_VC][DEPTH];

  logic [PW-1:0] head_q  [NUM_VC];
  logic [PW-1:0] head_d  [NUM_VC];
  logic [PW-1:0] tail_q  [NUM_VC];
  logic [PW-1:0] tail_d  [NUM_VC];
  logic [CW-1:0] count_q [NUM_VC];
  logic [CW-1:0] count_d [NUM_VC];
  vc_state_e     state_q [NUM_VC];
  vc_state_e     state_d [NUM_VC];
  logic          err_q, err_d;

  logic           in_vc_ok, out_vc_ok;
  logic [VCW-1:0] in_idx, out_idx;
  logic           in_full;
  logic           is_nope;
  logic           push_fire, pop_fire, overflow;

  // Out-of-range VC selects (non-power-of-two NUM_VC) are masked to VC0 for indexing only.
  assign in_vc_ok  = 32'(in_vc) < NUM_VC;
  assign out_vc_ok = 32'(out_vc) < NUM_VC;
  assign in_idx    = in_vc_ok  ? in_vc  : '0;
  assign out_idx   = out_vc_ok ? out_vc : '0;

  assign in_full   = (count_q[in_idx] == CW'(DEPTH));
  assign in_ready  = in_vc_ok && !in_full;
  assign out_valid = out_vc_ok && (count_q[out_idx] != '0);
  assign out_flit  = mem_q[out_idx][head_q[out_idx]];

`ifdef FLIT_BUF_DROP_NOPE_EN
  assign is_nope = (in_flit[FLIT_WIDTH-5:FLIT_WIDTH-8] == 4'd3);
`else
  assign is_nope = 1'b0;
`endif

  assign push_fire = in_valid && in_ready && !is_nope;
  assign pop_fire  = out_ready && out_valid;
  assign overflow  = in_valid && in_vc_ok && in_full;

  function automatic vc_state_e state_of(input logic [CW-1:0] cnt);
    if (cnt == '0) begin
      return StEmpty;
    end else if (cnt == CW'(DEPTH)) begin
      return StFull;
    end else if ((CW'(DEPTH) - cnt) <= CW'(AF_TH)) begin
      return StAlmostFull;
    end else begin
      return StVacant;
    end
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      logic push_v, pop_v;
      push_v     = push_fire && (in_idx == VCW'(v));
      pop_v      = pop_fire && (out_idx == VCW'(v));
      head_d[v]  = head_q[v] + PW'(pop_v);
      tail_d[v]  = tail_q[v] + PW'(push_v);
      count_d[v] = count_q[v] + CW'(push_v) - CW'(pop_v);
      // State tracks the next count so it is never a cycle behind vc_count.
      state_d[v] = state_of(count_d[v]);
    end
  end

  always_comb begin
    err_d = err_q;
    if (overflow) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v]  <= '0;
        tail_q[v]  <= '0;
        count_q[v] <= '0;
        state_q[v] <= StEmpty;
      end
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v]  <= head_d[v];
        tail_q[v]  <= tail_d[v];
        count_q[v] <= count_d[v];
        state_q[v] <= state_d[v];
      end
      err_q <= err_d;
    end
  end

  // Storage is never reset; validity is governed entirely by the counters.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[in_idx][tail_q[in_idx]] <= in_flit;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc_out
    assign vc_state[2*v +: 2]  = state_q[v];
    assign vc_count[CW*v +: CW] = count_q[v];
  end

  assign err_overflow = err_q;

endmodule

// File: tb/tb_flit_vc_buffer.sv
// Scoreboard bench for flit_vc_buffer with default parameters (128-bit, 2 VCs, depth 8, AF_TH 1).
module tb_flit_vc_buffer;

  localparam int unsigned FW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [0:0]    in_vc;
  logic [FW-1:0] in_flit;
  logic          in_ready;
  logic [0:0]    out_vc;
  logic          out_ready;
  logic          out_valid;
  logic [FW-1:0] out_flit;
  logic [3:0]    vc_state;
  logic [7:0]    vc_count;
  logic          err_overflow;
  logic          err_clear;

  int vectors = 0;
  int miscompares = 0;

  logic [FW-1:0] exp0[$];
  logic [FW-1:0] exp1[$];

  flit_vc_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_flit      (in_flit),
    .in_ready     (in_ready),
    .out_vc       (out_vc),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .vc_state     (vc_state),
    .vc_count     (vc_count),
    .err_overflow (err_overflow),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: a pop is requested mid-cycle; compare the head against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (out_vc == 1'b0 && exp0.size() > 0) begin
        check("pop_valid_vc0", FW'(out_valid), FW'(1));
        check("pop_data_vc0", out_flit, exp0.pop_front());
      end else if (out_vc == 1'b1 && exp1.size() > 0) begin
        check("pop_valid_vc1", FW'(out_valid), FW'(1));
        check("pop_data_vc1", out_flit, exp1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic vc, input logic [FW-1:0] f, input bit accept);
    in_valid = 1'b1;
    in_vc    = vc;
    in_flit  = f;
    if (accept) begin
      if (vc) exp1.push_back(f);
      else    exp0.push_back(f);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop(input logic vc);
    out_vc    = vc;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] nope_f, head_f;
    rst_n = 1'b0; in_valid = 0; in_vc = 0; in_flit = '0;
    out_vc = 0; out_ready = 0; err_clear = 0;
    tick(); tick();
    check("rst_count", FW'(vc_count), FW'(0));
    check("rst_state", FW'(vc_state), FW'(0));
    check("rst_out_valid", FW'(out_valid), FW'(0));
    check("rst_err", FW'(err_overflow), FW'(0));
    check("rst_in_ready", FW'(in_ready), FW'(1));
    rst_n = 1'b1;
    tick();

    // Basic FIFO order on VC0
    for (int i = 1; i <= 3; i++) push(1'b0, FW'(i), 1'b1);
    check("vc0_count3", FW'(vc_count[3:0]), FW'(3));
    check("vc0_vacant", FW'(vc_state[1:0]), FW'(1));
    for (int i = 0; i < 3; i++) pop(1'b0);
    check("vc0_empty_count", FW'(vc_count[3:0]), FW'(0));
    check("vc0_empty_state", FW'(vc_state[1:0]), FW'(0));

    // Fill VC1 to almost-full, full, then overflow
    for (int i = 0; i < 7; i++) push(1'b1, FW'(32'h100 + i), 1'b1);
    check("vc1_af_state", FW'(vc_state[3:2]), FW'(2));
    check("vc1_af_count", FW'(vc_count[7:4]), FW'(7));
    push(1'b1, FW'(32'h107), 1'b1);
    check("vc1_full_state", FW'(vc_state[3:2]), FW'(3));
    check("vc1_full_count", FW'(vc_count[7:4]), FW'(8));
    in_vc = 1'b1; #1;
    check("vc1_full_in_ready", FW'(in_ready), FW'(0));
    push(1'b1, FW'(32'hdead), 1'b0);
    check("ovf_err_set", FW'(err_overflow), FW'(1));
    check("ovf_count_held", FW'(vc_count[7:4]), FW'(8));
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("err_cleared", FW'(err_overflow), FW'(0));

    // Push VC0 while popping full VC1 in the same cycle
    in_valid = 1'b1; in_vc = 1'b0; in_flit = FW'(32'h200); exp0.push_back(FW'(32'h200));
    out_vc = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("cross_vc0_count", FW'(vc_count[3:0]), FW'(1));
    check("cross_vc1_count", FW'(vc_count[7:4]), FW'(7));
    check("cross_no_err", FW'(err_overflow), FW'(0));
    for (int i = 0; i < 7; i++) pop(1'b1);
    check("vc1_drained", FW'(vc_count[7:4]), FW'(0));

    // Steady push+pop at count 4 across pointer wrap
    for (int i = 1; i <= 3; i++) push(1'b0, FW'(32'h200 + i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_vc = 1'b0; in_flit = FW'(32'h300 + i);
      exp0.push_back(FW'(32'h300 + i));
      out_vc = 1'b0; out_ready = 1'b1;
      tick();
      check("steady_count4", FW'(vc_count[3:0]), FW'(4));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("steady_state", FW'(vc_state[1:0]), FW'(1));
    for (int i = 0; i < 4; i++) pop(1'b0);
    check("wrap_drained", FW'(vc_count[3:0]), FW'(0));

    // Async reset mid-stream with VC0=5 and error set
    for (int i = 0; i < 5; i++) push(1'b0, FW'(32'h400 + i), 1'b0);
    for (int i = 0; i < 9; i++) push(1'b1, FW'(32'h500 + i), 1'b0);
    check("pre_rst_vc0", FW'(vc_count[3:0]), FW'(5));
    check("pre_rst_err", FW'(err_overflow), FW'(1));
    out_vc = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", FW'(vc_count), FW'(0));
    check("async_rst_state", FW'(vc_state), FW'(0));
    check("async_rst_out_valid", FW'(out_valid), FW'(0));
    check("async_rst_err", FW'(err_overflow), FW'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // NOPE flit handling
    nope_f = {4'h0, 4'h3, 120'h0a};
    head_f = {4'h0, 4'h1, 120'h0b};
`ifdef FLIT_BUF_DROP_NOPE_EN
    push(1'b0, nope_f, 1'b0);
    push(1'b0, head_f, 1'b1);
    check("nope_count", FW'(vc_count[3:0]), FW'(1));
    pop(1'b0);
`else
    push(1'b0, nope_f, 1'b1);
    push(1'b0, head_f, 1'b1);
    check("nope_count", FW'(vc_count[3:0]), FW'(2));
    pop(1'b0);
    pop(1'b0);
`endif
    check("nope_drained", FW'(vc_count[3:0]), FW'(0));

    check("scoreboard_empty", FW'(exp0.size() + exp1.size()), FW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
